// File: rtl/aes_round_sequencer.sv
// Round controller for an iterative AES-128 datapath: sequences key/round selects,
// strobes the state load, and re-runs an encryption when the sbox parity check trips.
module aes_round_sequencer #(
    parameter int MAX_RETRY  = 2,
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       fault_detected,
    input  logic [3:0] fault_location,
    output logic       busy,
    output logic [3:0] key_index,
    output logic [1:0] round_sel,
    output logic       state_load,
    output logic       done,
    output logic       ct_valid,
    output logic       fault_flag,
    output logic [3:0] fault_round,
    output logic [3:0] fault_loc_q,
    output logic [2:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4,
        ST_RETRY = 3'd5,
        ST_ABORT = 3'd6
    } state_t;

    localparam logic [3:0] LAST_MID_KI = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] FINAL_KI    = 4'(NUM_ROUNDS);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t      state_r;
    state_t      next_state_s;

    logic        busy_r;
    logic [3:0]  key_index_r;
    logic [1:0]  round_sel_r;
    logic        state_load_r;
    logic        done_r;
    logic        ct_valid_r;
    logic        fault_flag_r;
    logic [3:0]  fault_round_r;
    logic [3:0]  fault_loc_r;
    logic [2:0]  retry_cnt_r;

    logic        busy_s;
    logic [3:0]  key_index_s;
    logic [1:0]  round_sel_s;
    logic        state_load_s;
    logic        done_s;

    logic        accept_s;
    logic        fault_seen_s;
    logic        can_retry_s;

    // Faults only count while a round is actually being computed.
    assign accept_s     = (state_r == ST_IDLE) && start;
    assign fault_seen_s = ((state_r == ST_ROUND) || (state_r == ST_FINAL)) && fault_detected;
    assign can_retry_s  = (retry_cnt_r < RETRY_LIMIT);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a detected fault overrides normal round progression.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_INIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                next_state_s = ST_ROUND;
            end
            ST_ROUND: begin
                if (fault_detected) begin
                    next_state_s = can_retry_s ? ST_RETRY : ST_ABORT;
                end else if (key_index_r == LAST_MID_KI) begin
                    next_state_s = ST_FINAL;
                end else begin
                    next_state_s = ST_ROUND;
                end
            end
            ST_FINAL: begin
                if (fault_detected) begin
                    next_state_s = can_retry_s ? ST_RETRY : ST_ABORT;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_DONE:  next_state_s = ST_IDLE;
            ST_RETRY: next_state_s = ST_INIT;
            ST_ABORT: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Output decode for the upcoming state so the outputs can be registered in step with it.
    always_comb begin
        busy_s       = 1'b0;
        key_index_s  = 4'd0;
        round_sel_s  = 2'b00;
        state_load_s = 1'b0;
        done_s       = 1'b0;
        case (next_state_s)
            ST_INIT: begin
                busy_s       = 1'b1;
                state_load_s = 1'b1;
            end
            ST_ROUND: begin
                busy_s       = 1'b1;
                key_index_s  = key_index_r + 4'd1;
                round_sel_s  = 2'b01;
                state_load_s = 1'b1;
            end
            ST_FINAL: begin
                busy_s       = 1'b1;
                key_index_s  = FINAL_KI;
                round_sel_s  = 2'b10;
                state_load_s = 1'b1;
            end
            ST_RETRY: busy_s = 1'b1;
            ST_DONE:  done_s = 1'b1;
            ST_ABORT: done_s = 1'b1;
            default:  busy_s = 1'b0;
        endcase
    end

    // Registered datapath control outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_r       <= 1'b0;
            key_index_r  <= 4'd0;
            round_sel_r  <= 2'b00;
            state_load_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            busy_r       <= busy_s;
            key_index_r  <= key_index_s;
            round_sel_r  <= round_sel_s;
            state_load_r <= state_load_s;
            done_r       <= done_s;
        end
    end

    // Completion status and fault capture; cleared when a new operation is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ct_valid_r    <= 1'b0;
            fault_flag_r  <= 1'b0;
            fault_round_r <= 4'd0;
            fault_loc_r   <= 4'd0;
            retry_cnt_r   <= 3'd0;
        end else if (accept_s) begin
            ct_valid_r    <= 1'b0;
            fault_flag_r  <= 1'b0;
            fault_round_r <= 4'd0;
            fault_loc_r   <= 4'd0;
            retry_cnt_r   <= 3'd0;
        end else begin
            if (next_state_s == ST_DONE) begin
                ct_valid_r <= 1'b1;
            end
            if (next_state_s == ST_ABORT) begin
                fault_flag_r <= 1'b1;
            end
            if (fault_seen_s) begin
                fault_round_r <= key_index_r;
                fault_loc_r   <= fault_location;
                if (can_retry_s) begin
                    retry_cnt_r <= retry_cnt_r + 3'd1;
                end
            end
        end
    end

    assign busy        = busy_r;
    assign key_index   = key_index_r;
    assign round_sel   = round_sel_r;
    assign state_load  = state_load_r;
    assign done        = done_r;
    assign ct_valid    = ct_valid_r;
    assign fault_flag  = fault_flag_r;
    assign fault_round = fault_round_r;
    assign fault_loc_q = fault_loc_r;
    assign retry_cnt   = retry_cnt_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: directed vector table plus randomized fault schedules
// checked cycle by cycle against an attempt-level model of the encryption sequence.
module tb_aes_round_sequencer;

    localparam int MAX_RETRY = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       fault_detected;
    logic [3:0] fault_location;
    logic       busy;
    logic [3:0] key_index;
    logic [1:0] round_sel;
    logic       state_load;
    logic       done;
    logic       ct_valid;
    logic       fault_flag;
    logic [3:0] fault_round;
    logic [3:0] fault_loc_q;
    logic [2:0] retry_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    aes_round_sequencer #(.MAX_RETRY(MAX_RETRY), .NUM_ROUNDS(10)) dut (
        .clock(clock), .reset(reset), .start(start),
        .fault_detected(fault_detected), .fault_location(fault_location),
        .busy(busy), .key_index(key_index), .round_sel(round_sel),
        .state_load(state_load), .done(done), .ct_valid(ct_valid),
        .fault_flag(fault_flag), .fault_round(fault_round),
        .fault_loc_q(fault_loc_q), .retry_cnt(retry_cnt)
    );

    // outs = {busy, key_index, round_sel, state_load, done}
    typedef struct packed {
        logic [8:0] outs;
        logic       flt;
        logic [3:0] loc;
    } cyc_t;

    // fm[a] bit k: fault asserted while key_index==k in attempt a
    typedef struct {
        logic [2:0][10:0] fm;
        logic [3:0]       loc;
        bit               idle_fault;
        logic [12:0]      exp_st;
        int               lat;
    } vec_t;

    cyc_t        exp_q[$];
    logic [12:0] exp_status;
    vec_t        vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected cycle trace: each attempt is INIT then rounds 1..10 until the first fault.
    task automatic build_model(input logic [2:0][10:0] fm, input logic [3:0] loc_base);
        int          retries;
        int          attempt;
        logic [3:0]  fr;
        logic [3:0]  fl;
        bit          finished;
        bit          aborted;
        bit          faulted;
        logic [10:0] m;
        cyc_t        c;
        retries  = 0;
        attempt  = 0;
        fr       = 4'd0;
        fl       = 4'd0;
        finished = 1'b0;
        aborted  = 1'b0;
        exp_q.delete();
        while (!finished) begin
            m       = fm[attempt];
            faulted = 1'b0;
            c.outs = {1'b1, 4'd0, 2'd0, 1'b1, 1'b0};
            c.flt  = m[0];
            c.loc  = loc_base + 4'(attempt);
            exp_q.push_back(c);
            for (int k = 1; k <= 10 && !faulted; k++) begin
                c.outs = {1'b1, 4'(k), (k == 10) ? 2'd2 : 2'd1, 1'b1, 1'b0};
                c.flt  = m[k];
                c.loc  = loc_base + 4'(attempt);
                exp_q.push_back(c);
                if (m[k]) begin
                    faulted = 1'b1;
                    fr = 4'(k);
                    fl = loc_base + 4'(attempt);
                end
            end
            if (!faulted) begin
                c.outs = {1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
                c.flt  = 1'b0;
                c.loc  = 4'd0;
                exp_q.push_back(c);
                finished = 1'b1;
            end else if (retries < MAX_RETRY) begin
                retries++;
                attempt++;
                m = fm[attempt];
                c.outs = {1'b1, 4'd0, 2'd0, 1'b0, 1'b0};
                c.flt  = m[0];
                c.loc  = loc_base + 4'(attempt);
                exp_q.push_back(c);
            end else begin
                c.outs = {1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
                c.flt  = 1'b0;
                c.loc  = 4'd0;
                exp_q.push_back(c);
                aborted  = 1'b1;
                finished = 1'b1;
            end
        end
        exp_status = {~aborted, aborted, 3'(retries), fr, fl};
    endtask

    // Drive one operation and compare every cycle; done_at is the cycle (relative to start sampling) of done.
    task automatic run_op(input logic [2:0][10:0] fm, input logic [3:0] loc_base,
                          input bit idle_fault, input bit hold_start, input bit noise,
                          input bit accepted, output int done_at);
        build_model(fm, loc_base);
        done_at = 0;
        if (!accepted) begin
            @(negedge clock);
            start          = 1'b1;
            fault_detected = idle_fault;
            fault_location = 4'hF;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            start          = hold_start ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            fault_detected = exp_q[i].flt;
            fault_location = exp_q[i].loc;
            check("cycle", 32'({busy, key_index, round_sel, state_load, done}), 32'(exp_q[i].outs));
            if (done && done_at == 0) done_at = i + 1;
        end
        check("status", 32'({ct_valid, fault_flag, retry_cnt, fault_round, fault_loc_q}), 32'(exp_status));
        @(negedge clock);
        start          = hold_start;
        fault_detected = 1'b0;
        check("idle", 32'({busy, key_index, round_sel, state_load, done}), 32'd0);
        check("held", 32'({ct_valid, fault_flag, retry_cnt, fault_round, fault_loc_q}), 32'(exp_status));
    endtask

    initial begin
        int               lat;
        int               lat2;
        logic [2:0][10:0] rfm;

        vecs[0] = '{fm: {11'h000, 11'h000, 11'h000}, loc: 4'h0, idle_fault: 1'b0,
                    exp_st: {1'b1, 1'b0, 3'd0, 4'd0, 4'h0}, lat: 12};
        vecs[1] = '{fm: {11'h000, 11'h000, 11'h020}, loc: 4'h3, idle_fault: 1'b0,
                    exp_st: {1'b1, 1'b0, 3'd1, 4'd5, 4'h3}, lat: 19};
        vecs[2] = '{fm: {11'h7FF, 11'h7FF, 11'h7FF}, loc: 4'hA, idle_fault: 1'b0,
                    exp_st: {1'b0, 1'b1, 3'd2, 4'd1, 4'hC}, lat: 9};
        vecs[3] = '{fm: {11'h000, 11'h000, 11'h001}, loc: 4'h7, idle_fault: 1'b1,
                    exp_st: {1'b1, 1'b0, 3'd0, 4'd0, 4'h0}, lat: 12};
        vecs[4] = '{fm: {11'h000, 11'h400, 11'h400}, loc: 4'h5, idle_fault: 1'b0,
                    exp_st: {1'b1, 1'b0, 3'd2, 4'd10, 4'h6}, lat: 36};
        vecs[5] = '{fm: {11'h400, 11'h008, 11'h200}, loc: 4'h1, idle_fault: 1'b0,
                    exp_st: {1'b0, 1'b1, 3'd2, 4'd10, 4'h3}, lat: 28};

        reset          = 1'b0;
        start          = 1'b0;
        fault_detected = 1'b0;
        fault_location = 4'd0;
        repeat (3) @(negedge clock);
        check("reset_state", 32'({busy, key_index, round_sel, state_load, done, ct_valid,
                                  fault_flag, fault_round, fault_loc_q, retry_cnt}), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_after_reset", 32'({busy, done, state_load}), 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].fm, vecs[v].loc, vecs[v].idle_fault, 1'b0, 1'b0, 1'b0, lat);
            check("vec_status", 32'(exp_status), 32'(vecs[v].exp_st));
            check("vec_latency", 32'(lat), 32'(vecs[v].lat));
        end

        // start held through an operation: ignored while busy, then a second op right after the idle cycle
        run_op({11'h000, 11'h000, 11'h000}, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        check("hold_latency", 32'(lat), 32'd12);
        run_op({11'h000, 11'h000, 11'h000}, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, lat2);
        check("b2b_latency", 32'(lat2), 32'd12);

        // asynchronous reset in the middle of round 7
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        check("pre_reset_ki", 32'(key_index), 32'd7);
        #2 reset = 1'b0;
        #1 check("async_reset", 32'({busy, key_index, round_sel, state_load, done, ct_valid,
                                     fault_flag, fault_round, fault_loc_q, retry_cnt}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            check("no_done_after_reset", 32'({busy, done}), 32'd0);
        end
        run_op({11'h000, 11'h000, 11'h000}, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        check("post_reset_latency", 32'(lat), 32'd12);

        // randomized fault schedules with start noise while busy
        for (int n = 0; n < 25; n++) begin
            for (int a = 0; a < 3; a++) begin
                rfm[a] = 11'd0;
                if ($urandom_range(0, 2) == 0) rfm[a] = 11'd1 << $urandom_range(1, 10);
                rfm[a][0] = 1'($urandom_range(0, 1));
            end
            run_op(rfm, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
